// File: rtl/mux_scan_n.sv
// -----------------------------------------------------------------------------
// mux_scan_n
//
// Registered N-channel data multiplexer with two ways of choosing the channel:
//   mode = 0 : manual select, the channel index comes from sel
//   mode = 1 : auto round-robin scan, the channel index comes from ptr, which
//              steps through 0..N_CH-1 once per cycle the output can accept
//
// The output stage is a single valid/ready register. A new beat is captured
// only when the register is empty or is being drained in the same cycle, so a
// stalled downstream freezes both the held beat and the scan pointer.
//
// Channels that are not selected, or are selected while their valid flag is
// low, are ignored. There is no per-channel buffering.
//
// Optional feature (compile-time macro MUX_SCAN_PARITY_EN):
//   When defined, an extra output dout_par carries the XOR of the dout bits.
//   It is registered together with dout and reset to 0. When undefined the
//   port does not exist.
//
// Parameters
//   N_CH       number of input channels (2..16)
//   W          data width per channel (1..32)
//   SW         channel-index width, clog2(N_CH), minimum 1 (derived)
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   mode       0 = manual select, 1 = round-robin scan
//   sel        manual channel index (only used when mode = 0)
//   din        packed channel data, channel k at bits [k*W +: W]
//   in_valid   per-channel data-valid flags
//   out_ready  downstream accept
//   dout       registered selected data
//   dout_ch    channel index that dout came from
//   out_valid  dout/dout_ch hold a beat
//   ptr        current channel pointer (debug echo)
//   mode_q     registered mode (debug echo)
//   dout_par   XOR of dout bits (only with MUX_SCAN_PARITY_EN)
// -----------------------------------------------------------------------------
module mux_scan_n #(
  parameter  int N_CH = 4,
  parameter  int W    = 8,
  localparam int SW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [SW-1:0]     sel,
  input  logic [N_CH*W-1:0] din,
  input  logic [N_CH-1:0]   in_valid,
  input  logic              out_ready,
  output logic [W-1:0]      dout,
  output logic [SW-1:0]     dout_ch,
  output logic              out_valid,
  output logic [SW-1:0]     ptr,
  output logic              mode_q
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic              dout_par
`endif
);

  localparam logic [SW-1:0] LAST_CH = SW'(N_CH - 1);

  // ---------------------------------------------------------------------------
  // Channel selection
  // ---------------------------------------------------------------------------
  logic          load_en;
  logic          mode_rise;
  logic [SW-1:0] cur_ch;
  logic          cur_hit;
  logic          cur_valid;
  logic [W-1:0]  cur_data;
  logic          do_load;
  logic [SW-1:0] ptr_adv;

  always_comb begin
    load_en   = ~out_valid | out_ready;
    // Entering scan mode restarts the scan at channel 0 on the next cycle.
    mode_rise = mode & ~mode_q;
    cur_ch    = mode ? ptr : sel;
  end

  // Decoding through an explicit match loop means an index at or beyond N_CH
  // simply never hits, which covers non-power-of-two channel counts.
  always_comb begin
    cur_hit   = 1'b0;
    cur_valid = 1'b0;
    cur_data  = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (cur_ch == SW'(k)) begin
        cur_hit   = 1'b1;
        cur_valid = in_valid[k];
        cur_data  = din[k*W +: W];
      end
    end
  end

  always_comb begin
    do_load = load_en & ~mode_rise & cur_hit & cur_valid;
    // Compare with >= so an out-of-range pointer still returns to 0.
    ptr_adv = (ptr >= LAST_CH) ? '0 : ptr + SW'(1);
  end

  // ---------------------------------------------------------------------------
  // Next-state computation
  // ---------------------------------------------------------------------------
  logic [W-1:0]  dout_n;
  logic [SW-1:0] dout_ch_n;
  logic          out_valid_n;
  logic [SW-1:0] ptr_n;
`ifdef MUX_SCAN_PARITY_EN
  logic          dout_par_n;
`endif

  always_comb begin
    dout_n      = dout;
    dout_ch_n   = dout_ch;
    out_valid_n = out_valid;
    ptr_n       = ptr;
`ifdef MUX_SCAN_PARITY_EN
    dout_par_n  = dout_par;
`endif

    if (mode_rise) begin
      // Transition edge: pointer restarts, nothing is captured. A held beat
      // that is not being drained stays put.
      ptr_n = '0;
      if (load_en) begin
        out_valid_n = 1'b0;
      end
    end else if (load_en) begin
      out_valid_n = do_load;
      if (do_load) begin
        dout_n    = cur_data;
        dout_ch_n = cur_ch;
`ifdef MUX_SCAN_PARITY_EN
        dout_par_n = ^cur_data;
`endif
      end
      // Scan advances whether or not the visited channel had data; in manual
      // mode the pointer tracks the requested channel.
      ptr_n = mode ? ptr_adv : sel;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      dout      <= '0;
      dout_ch   <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
      mode_q    <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      dout_par  <= 1'b0;
`endif
    end else begin
      dout      <= dout_n;
      dout_ch   <= dout_ch_n;
      out_valid <= out_valid_n;
      ptr       <= ptr_n;
      mode_q    <= mode;
`ifdef MUX_SCAN_PARITY_EN
      dout_par  <= dout_par_n;
`endif
    end
  end

endmodule

// File: tb/tb_mux_scan_n.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_n
//
// Self-checking bench for mux_scan_n (N_CH=4, W=8). A driver applies directed
// and random stimulus on the falling edge and advances a behavioural model;
// beats the model expects to be captured are pushed into a scoreboard queue.
// A separate monitor compares the register state every cycle and pops the
// queue whenever the DUT presents a beat that is accepted downstream.
// Define MUX_SCAN_PARITY_EN to also exercise dout_par.
// -----------------------------------------------------------------------------
module tb_mux_scan_n;

  localparam int N_CH = 4;
  localparam int W    = 8;
  localparam int SW   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              mode;
  logic [SW-1:0]     sel;
  logic [N_CH*W-1:0] din;
  logic [N_CH-1:0]   in_valid;
  logic              out_ready;
  logic [W-1:0]      dout;
  logic [SW-1:0]     dout_ch;
  logic              out_valid;
  logic [SW-1:0]     ptr;
  logic              mode_q;
`ifdef MUX_SCAN_PARITY_EN
  logic              dout_par;
`endif

  always #5 clk = ~clk;

  mux_scan_n #(.N_CH(N_CH), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .din       (din),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .dout_ch   (dout_ch),
    .out_valid (out_valid),
    .ptr       (ptr),
    .mode_q    (mode_q)
`ifdef MUX_SCAN_PARITY_EN
    ,
    .dout_par  (dout_par)
`endif
  );

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int data;
    int ch;
  } beat_t;

  beat_t sb[$];

  // Model of the observable register state
  int m_valid = 0;
  int m_dout  = 0;
  int m_ch    = 0;
  int m_ptr   = 0;
  int m_modeq = 0;
  int m_par   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Effect of the upcoming rising edge given the inputs currently applied.
  task automatic model_update();
    int ld_en;
    int c;
    logic [W-1:0] d;
    if (rst) begin
      m_valid = 0; m_dout = 0; m_ch = 0; m_ptr = 0; m_modeq = 0; m_par = 0;
      sb.delete();
    end else begin
      ld_en = (m_valid == 0 || out_ready) ? 1 : 0;
      if (mode && m_modeq == 0) begin
        m_ptr = 0;
        if (ld_en != 0) m_valid = 0;
      end else if (ld_en != 0) begin
        c = mode ? m_ptr : int'(sel);
        if (c < N_CH && in_valid[c]) begin
          d       = din[c*W +: W];
          m_dout  = int'(d);
          m_ch    = c;
          m_valid = 1;
          m_par   = int'(^d);
          sb.push_back('{int'(d), c});
        end else begin
          m_valid = 0;
        end
        m_ptr = mode ? (m_ptr + 1) % N_CH : int'(sel);
      end
      m_modeq = int'(mode);
    end
  endtask

  task automatic step(input logic r, input logic m, input logic [SW-1:0] s,
                      input logic [N_CH*W-1:0] d, input logic [N_CH-1:0] iv,
                      input logic rdy);
    @(negedge clk);
    rst = r; mode = m; sel = s; din = d; in_valid = iv; out_ready = rdy;
    #3;
    model_update();
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // Monitor: state checks every cycle, scoreboard pop on each accepted beat.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        chk("out_valid", int'(out_valid), m_valid);
        chk("dout", int'(dout), m_dout);
        chk("dout_ch", int'(dout_ch), m_ch);
        chk("ptr", int'(ptr), m_ptr);
        chk("mode_q", int'(mode_q), m_modeq);
`ifdef MUX_SCAN_PARITY_EN
        chk("dout_par", int'(dout_par), m_par);
`endif
        if (out_valid && out_ready && !rst) begin
          if (sb.size() == 0) begin
            chk("xfer_unexpected", 1, 0);
          end else begin
            b = sb.pop_front();
            chk("xfer_data", int'(dout), b.data);
            chk("xfer_ch", int'(dout_ch), b.ch);
          end
        end
      end
    end
  end

  localparam logic [N_CH*W-1:0] DIN_SCAN = {8'h13, 8'h12, 8'h11, 8'h10};

  initial begin
    logic [N_CH*W-1:0] dm;
    logic md;
    rst = 1'b1; mode = 1'b0; sel = '0; din = '0; in_valid = '0; out_ready = 1'b0;

    step(1, 0, 0, '0, '0, 0);
    mon_en = 1'b1;

    // Manual select of channel 2
    dm = {8'h00, 8'hA5, 8'h00, 8'h00};
    step(0, 0, 2, dm, 4'b0100, 1);
    after_edge();
    chk("man_dout", int'(dout), 'hA5);
    chk("man_ch", int'(dout_ch), 2);
    chk("man_valid", int'(out_valid), 1);

    // Scan from reset, all channels valid
    step(1, 1, 0, DIN_SCAN, 4'hF, 1);
    step(0, 1, 0, DIN_SCAN, 4'hF, 1);
    after_edge();
    chk("scan_rise_valid", int'(out_valid), 0);
    chk("scan_rise_ptr", int'(ptr), 0);
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 0, DIN_SCAN, 4'hF, 1);
      after_edge();
      chk("scan_seq", int'(dout), 'h10 + (k % 4));
    end

    // Backpressure while holding 0x11
    step(0, 1, 0, DIN_SCAN, 4'hF, 1);
    after_edge();
    chk("bp_load", int'(dout), 'h11);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, DIN_SCAN, 4'hF, 0);
      after_edge();
      chk("bp_hold_dout", int'(dout), 'h11);
      chk("bp_hold_ptr", int'(ptr), 2);
    end
    step(0, 1, 0, DIN_SCAN, 4'hF, 1);
    after_edge();
    chk("bp_resume", int'(dout), 'h12);

    // Skip channels without valid data
    step(1, 1, 0, DIN_SCAN, 4'b0101, 1);
    step(0, 1, 0, DIN_SCAN, 4'b0101, 1);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, DIN_SCAN, 4'b0101, 1);
      after_edge();
      chk("skip_valid", int'(out_valid), (k % 2 == 0) ? 1 : 0);
      if (k % 2 == 0) chk("skip_ch", int'(dout_ch), k);
    end

    // Reset while a beat is stalled
    step(0, 0, 1, DIN_SCAN, 4'hF, 1);
    step(0, 0, 1, DIN_SCAN, 4'hF, 0);
    step(1, 0, 1, DIN_SCAN, 4'hF, 0);
    after_edge();
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_ptr", int'(ptr), 0);
    chk("rst_dout", int'(dout), 0);

`ifdef MUX_SCAN_PARITY_EN
    step(0, 0, 0, {24'h0, 8'h07}, 4'b0001, 1);
    after_edge();
    chk("par_07", int'(dout_par), 1);
    step(0, 0, 0, {24'h0, 8'h03}, 4'b0001, 1);
    after_edge();
    chk("par_03", int'(dout_par), 0);
`endif

    // Random traffic with mode switches and occasional resets
    md = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) md = ~md;
      step(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0, md,
           SW'($urandom_range(0, N_CH - 1)), N_CH*W'($urandom),
           N_CH'($urandom_range(0, 15)),
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end

    // Drain and idle
    for (int i = 0; i < 4; i++) step(0, 0, 0, '0, '0, 1);
    @(negedge clk);
    #2;
    chk("sb_residual", sb.size(), m_valid);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
